// File: rtl/fibo_datapath.sv
// fibo_datapath: four-entry register file plus combinational ALU for the
// Fibonacci sequence engine. One register-to-register operation per clock.
// RESULT, ZERO_FLAG and OVF are driven straight from flops.
//
// Optional feature macro: FIBO_DP_OVF_EN
//   defined   -> OVF is a sticky unsigned carry/borrow flag, cleared by a
//                committed load of DATA_IN.
//   undefined -> OVF is tied to 0 and no carry logic is built.
module fibo_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             load_data,
  input  logic [2:0]       alu_opcode,
  input  logic [1:0]       rd_addr1,
  input  logic [1:0]       rd_addr2,
  input  logic [1:0]       wrt_addr,
  input  logic             wrt_en,
  output logic             ZERO_FLAG,
  output logic [WIDTH-1:0] RESULT,
  output logic             OVF
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_INC  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

  // ALU result, truncated modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] alu_result(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_PASS: r = a;
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_DEC:  r = a - ONE_W;
      OP_INC:  r = a + ONE_W;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ZERO_W;
    endcase
    return r;
  endfunction

`ifdef FIBO_DP_OVF_EN
  // Unsigned carry-out for add/increment, borrow for subtract/decrement.
  function automatic logic alu_overflow(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0] sum_ext;
    logic           ov;
    sum_ext = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD:  ov = sum_ext[WIDTH];
      OP_SUB:  ov = (a < b);
      OP_DEC:  ov = (a == ZERO_W);
      OP_INC:  ov = (a == ONES_W);
      default: ov = 1'b0;
    endcase
    return ov;
  endfunction
`endif

  logic [WIDTH-1:0] regs_r [4];
  logic [WIDTH-1:0] rd_a_s;
  logic [WIDTH-1:0] rd_b_s;
  logic [WIDTH-1:0] alu_s;
  logic [WIDTH-1:0] wd_s;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;

  // Asynchronous read ports; a same-cycle write is not bypassed, so reads see the old value.
  always_comb begin
    rd_a_s = regs_r[rd_addr1];
    rd_b_s = regs_r[rd_addr2];
  end

  // ALU evaluation and write-data select between external operand and ALU.
  always_comb begin
    alu_s = alu_result(alu_opcode, rd_a_s, rd_b_s);
    if (load_data) begin
      wd_s = DATA_IN;
    end else begin
      wd_s = alu_s;
    end
  end

  // Register file write port; reset clears all entries.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      regs_r[0] <= ZERO_W;
      regs_r[1] <= ZERO_W;
      regs_r[2] <= ZERO_W;
      regs_r[3] <= ZERO_W;
    end else if (wrt_en) begin
      regs_r[wrt_addr] <= wd_s;
    end
  end

  // Registered copy of the committed write data and its zero status.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      result_r <= ZERO_W;
      zero_r   <= 1'b0;
    end else if (wrt_en) begin
      result_r <= wd_s;
      zero_r   <= (wd_s == ZERO_W);
    end
  end

  assign RESULT    = result_r;
  assign ZERO_FLAG = zero_r;

`ifdef FIBO_DP_OVF_EN
  logic ovf_r;
  logic ovf_set_s;

  // Overflow detection only matters when the ALU result is what gets written.
  always_comb begin
    if (load_data) begin
      ovf_set_s = 1'b0;
    end else begin
      ovf_set_s = alu_overflow(alu_opcode, rd_a_s, rd_b_s);
    end
  end

  // Sticky overflow: set by an overflowing ALU write, cleared by a DATA_IN load.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_r <= 1'b0;
    end else if (wrt_en) begin
      if (load_data) begin
        ovf_r <= 1'b0;
      end else if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign OVF = ovf_r;
`else
  assign OVF = 1'b0;
`endif

endmodule

// File: doc/fibo_datapath.md
# fibo_datapath

Register-file-plus-ALU datapath for the Fibonacci sequence engine. Sits directly downstream of the FSM/decoder stage. It consumes `alu_opcode`, `rd_addr1`, `rd_addr2`, `wrt_addr`, `wrt_en` and `load_data`, executes one register-to-register operation per clock, and returns `ZERO_FLAG` to the FSM so it can detect loop termination. The current Fibonacci term is exposed on `RESULT`.

## Interface
- `WIDTH`, default 8: data width of registers, ALU, `DATA_IN` and `RESULT`.

- `CLK` input 1: single system clock; all state updates on the rising edge.
- `RST` input 1: asynchronous, active-low reset.
- `DATA_IN` input WIDTH: external operand (e.g. term count N), written when `load_data`=1.
- `load_data` input 1: write-data select; 1 = `DATA_IN`, 0 = ALU result.
- `alu_opcode` input 3: ALU operation select.
- `rd_addr1` input 2: register file read port A address.
- `rd_addr2` input 2: register file read port B address.
- `wrt_addr` input 2: write port address.
- `wrt_en` input 1: write strobe; 1 = commit write data this edge.
- `ZERO_FLAG` output 1: registered; 1 when the last committed write data was 0.
- `RESULT` output WIDTH: registered copy of the last committed write data.
- `OVF` output 1: sticky unsigned-overflow flag (see Configuration).

## Operation
- Register file: R0..R3, each WIDTH bits. Reads are asynchronous: A = R[`rd_addr1`], B = R[`rd_addr2`].
- ALU is combinational. Results are truncated to WIDTH bits, unsigned, modulo 2^WIDTH.
  - 000: A
  - 001: A+B
  - 010: A−B
  - 011: A−1
  - 100: A+1
  - 101: A&B
  - 110: A|B
  - 111: A^B
- Write data WD = `load_data` ? `DATA_IN` : ALU(A,B).
- On a rising edge with `wrt_en`=1, all of the following update together:
  - R[`wrt_addr`] ← WD
  - `ZERO_FLAG` ← (WD==0)
  - `RESULT` ← WD
- With `wrt_en`=0, no state changes. `alu_opcode` and `load_data` are don't-care.
- Read/write hazard: a read of a register being written in the same cycle returns the old value. R1 ← R1−1 therefore completes in one cycle with no bypass.
- `rd_addr1`==`rd_addr2` is legal; A+B with both on R2 yields 2·R2.
- Reset values (RST=0, asynchronous): R0..R3=0, `ZERO_FLAG`=0, `RESULT`=0, `OVF`=0. Reset asserted mid-operation aborts the write in progress; state is 0 on release. The first edge after release behaves normally.

## Timing
- Control inputs and `DATA_IN` are sampled on the rising `CLK` edge and must be stable before it. The combinational path is read mux → ALU → write mux.
- Write latency is 1 cycle: the register, `ZERO_FLAG`, `RESULT` and `OVF` all reflect a cycle-n write after edge n. The FSM sees `ZERO_FLAG` for the write it issued in cycle n during cycle n+1.
- Back-to-back writes every cycle are supported with no stalls.
- `ZERO_FLAG`, `RESULT` and `OVF` are driven directly from flops; no combinational path from inputs to outputs.

## Configuration
- `FIBO_DP_OVF_EN` defined:
  - `OVF` is set on any committed write where `load_data`=0 and the opcode overflows the unsigned range:
    - 001 or 100 with carry-out
    - 010 or 011 with borrow
  - Once set, it stays set until reset or until a committed write with `load_data`=1.
  - Set and clear in the same write cannot occur, because set requires `load_data`=0.
- `FIBO_DP_OVF_EN` undefined: `OVF` is constant 0 and no carry logic is synthesized.

## Test plan
- Reset: hold RST=0 with random inputs and clock running → R0..R3, `RESULT`, `ZERO_FLAG`, `OVF` all 0. Release RST → no state change until the first `wrt_en`=1.
- Load and decrement to zero (WIDTH=8):
  - `load_data`=1, `DATA_IN`=3, `wrt_addr`=3 → `RESULT`=3, `ZERO_FLAG`=0.
  - Then three cycles of opcode 011 with `rd_addr1`=3, `wrt_addr`=3 → `RESULT` 2,1,0; `ZERO_FLAG`=1 only after the third edge.
- Fibonacci step:
  - Preload R0=0, R1=1.
  - Repeat: R2←R0+R1, R0←R1, R1←R2 (opcodes 001, 000, 000).
  - → `RESULT` after each add = 1,2,3,5,8,13.
- Read-during-write: R1=5, opcode 001 with `rd_addr1`=`rd_addr2`=`wrt_addr`=1 → R1=10 after one edge. The ALU in that cycle used the old value 5.
- Overflow with `FIBO_DP_OVF_EN`:
  - R0=200, R1=100, R2←R0+R1 → `RESULT`=44, `OVF`=1.
  - A later `load_data`=1 write → `OVF`=0.
  - Without the macro → `OVF` stays 0 throughout.
- Write gating and mid-op reset:
  - `wrt_en`=0 with varying opcodes and addresses for 4 cycles → all outputs unchanged.
  - Assert RST between edges during a write sequence → outputs go to 0 immediately, without waiting for `CLK`.
